// File: rtl/uart_rx_cfg.sv
// UART receiver with a fractional NCO bit clock, 3-sample majority voting and configurable framing.
// Supports start-glitch rejection, break detection and a valid/ready output that reports overruns.
module uart_rx_cfg #(
  parameter int clk_hz      = 50_000_000,
  parameter int baud        = 115_200,
  parameter int oversample  = 16,
  parameter int ACC_width   = 24,
  parameter int data_bits   = 8,
  parameter int parity_mode = 0,
  parameter int stop_bits   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_i,
  output logic [data_bits-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 overrun_err,
  output logic                 break_det,
  output logic                 busy
);
  localparam int CW = $clog2(oversample);
  localparam int BW = $clog2(data_bits + 1);
  localparam logic [CW-1:0] M_LO  = CW'(oversample / 2 - 1);
  localparam logic [CW-1:0] M_MID = CW'(oversample / 2);
  localparam logic [CW-1:0] M_HI  = CW'(oversample / 2 + 1);
  localparam logic [CW-1:0] C_END = CW'(oversample - 1);
  localparam logic [BW-1:0] DB_END  = BW'(data_bits);
  localparam logic [BW-1:0] SB_LAST = BW'(stop_bits - 1);
  localparam logic [63:0] NCO_NUM = 64'(baud) * 64'(oversample) * (64'd1 << ACC_width);
  localparam logic [63:0] NCO_INC = (NCO_NUM + 64'(clk_hz / 2)) / 64'(clk_hz);
  localparam logic [ACC_width:0] INC = NCO_INC[ACC_width:0];

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state, state_n;

  logic rx_meta, rx_sync;
  logic [ACC_width:0] phase, phase_sum;
  logic os_tick;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [BW-1:0] bit_idx;
  logic [data_bits-1:0] shift;
  logic s_lo, s_mid, vote, at_vote, at_end;
  logic par_bit, ferr_acc, seen_one;
  logic do_shift, do_par, do_stop, bit_clr, done, brk;
  logic frame_perr, frame_ferr;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_sync <= rx_meta;
    end

  // Carry out of the accumulator is the oversample tick; the carry bit is dropped each cycle.
  assign phase_sum = phase + INC;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      phase   <= '0;
      os_tick <= 1'b0;
    end else begin
      phase   <= {1'b0, phase_sum[ACC_width-1:0]};
      os_tick <= phase_sum[ACC_width];
    end

  assign cnt_nxt = (cnt == C_END) ? '0 : cnt + 1'b1;
  assign at_vote = (cnt_nxt == M_HI);
  assign at_end  = (cnt_nxt == C_END);
  assign vote    = (s_lo & s_mid) | (s_lo & rx_sync) | (s_mid & rx_sync);

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;

  always_comb begin
    state_n  = state;
    do_shift = 1'b0;
    do_par   = 1'b0;
    do_stop  = 1'b0;
    bit_clr  = 1'b0;
    done     = 1'b0;
    brk      = 1'b0;
    if (os_tick) begin
      case (state)
        IDLE:  if (!rx_sync) state_n = START;
        START: if (at_vote && vote) state_n = IDLE;
               else if (at_end)     state_n = DATA;
        DATA: begin
          do_shift = at_vote;
          if (at_end && bit_idx == DB_END) begin
            bit_clr = 1'b1;
            state_n = (parity_mode != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          do_par = at_vote;
          if (at_end) state_n = STOP;
        end
        // Completing at mid-bit of the last stop leaves half a bit to resync on the next start.
        STOP: if (at_vote) begin
          do_stop = 1'b1;
          if (bit_idx == SB_LAST) begin
            done = 1'b1;
            if (!(seen_one || vote)) begin
              brk     = 1'b1;
              state_n = BREAK;
            end else begin
              state_n = IDLE;
            end
          end
        end
        BREAK:   if (rx_sync) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt      <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      s_lo     <= 1'b0;
      s_mid    <= 1'b0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
      seen_one <= 1'b0;
    end else begin
      if (os_tick) begin
        cnt <= (state == IDLE) ? '0 : cnt_nxt;
        if (cnt_nxt == M_LO)  s_lo  <= rx_sync;
        if (cnt_nxt == M_MID) s_mid <= rx_sync;
      end
      if (state == IDLE) begin
        bit_idx  <= '0;
        seen_one <= 1'b0;
        ferr_acc <= 1'b0;
      end else begin
        if (bit_clr)                 bit_idx <= '0;
        else if (do_shift || do_stop) bit_idx <= bit_idx + 1'b1;
        if ((do_shift || do_par || do_stop) && vote) seen_one <= 1'b1;
        if (do_stop && !vote) ferr_acc <= 1'b1;
      end
      if (do_shift) shift <= {vote, shift[data_bits-1:1]};
      if (do_par)   par_bit <= vote;
    end

  assign frame_perr = (parity_mode == 1) ? (^shift ^ par_bit) :
                      (parity_mode == 2) ? ~(^shift ^ par_bit) : 1'b0;
  assign frame_ferr = ferr_acc | ~vote;

  // A transfer in the completion cycle frees the register, so the new word loads instead of overrunning.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data        <= '0;
      valid       <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
      break_det   <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      break_det   <= brk;
      if (done && !brk) begin
        if (!valid || ready) begin
          data        <= shift;
          parity_err  <= frame_perr;
          framing_err <= frame_ferr;
          valid       <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end

  assign busy = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed 8N1 corner cases, a 7E2 vector table and randomized 9O2 frames.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
  localparam real BA = 1.0e9 / 115200.0;
  localparam real BB = 1.0e9 / 460800.0;
  localparam real BC = 1.0e9 / 500000.0;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst_a, rst_bc;
  logic rx_a, rx_b, rx_c, ready_a, ready_b, ready_c;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic [8:0] data_c;
  logic valid_a, valid_b, valid_c, pe_a, pe_b, pe_c, fe_a, fe_b, fe_c;
  logic ov_a, ov_b, ov_c, bk_a, bk_b, bk_c, busy_a, busy_b, busy_c;

  uart_rx_cfg u_a (.clk(clk), .rst(rst_a), .rx_i(rx_a), .data(data_a), .valid(valid_a), .ready(ready_a),
    .parity_err(pe_a), .framing_err(fe_a), .overrun_err(ov_a), .break_det(bk_a), .busy(busy_a));
  uart_rx_cfg #(.baud(460_800), .data_bits(7), .parity_mode(1), .stop_bits(2)) u_b (.clk(clk), .rst(rst_bc),
    .rx_i(rx_b), .data(data_b), .valid(valid_b), .ready(ready_b), .parity_err(pe_b), .framing_err(fe_b),
    .overrun_err(ov_b), .break_det(bk_b), .busy(busy_b));
  uart_rx_cfg #(.baud(500_000), .oversample(8), .data_bits(9), .parity_mode(2), .stop_bits(2)) u_c (.clk(clk),
    .rst(rst_bc), .rx_i(rx_c), .data(data_c), .valid(valid_c), .ready(ready_c), .parity_err(pe_c),
    .framing_err(fe_c), .overrun_err(ov_c), .break_det(bk_c), .busy(busy_c));

  logic [8:0] dw [3];
  logic [2:0] valid_w, ov_w, bk_w, busy_w, pe_w, fe_w;
  assign dw[0] = {1'b0, data_a};
  assign dw[1] = {2'b0, data_b};
  assign dw[2] = data_c;
  assign valid_w = {valid_c, valid_b, valid_a};
  assign ov_w    = {ov_c, ov_b, ov_a};
  assign bk_w    = {bk_c, bk_b, bk_a};
  assign busy_w  = {busy_c, busy_b, busy_a};
  assign pe_w    = {pe_c, pe_b, pe_a};
  assign fe_w    = {fe_c, fe_b, fe_a};

  int ntests = 0, nfail = 0;
  int nacc[3], vcyc[3], vrise[3], novr[3], nbrk[3], nbusy[3];
  int sacc[3], svcyc[3], svrise[3], sovr[3], sbrk[3], sbusy[3];
  int last_d[3], last_pe[3], last_fe[3];
  logic [2:0] valid_prev = '0, busy_prev = '0;

  typedef struct { int d; int pe; int fe; } exp_t;
  exp_t exp_c[$];

  typedef struct {
    logic [8:0] d; logic pflip; logic [1:0] stopv;
    int brk; int pe; int fe;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial for (int k = 0; k < 3; k++) begin
    nacc[k] = 0; vcyc[k] = 0; vrise[k] = 0; novr[k] = 0; nbrk[k] = 0; nbusy[k] = 0;
  end

  always @(negedge clk) begin
    logic r;
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      r = (k == 0) ? ready_a : (k == 1) ? ready_b : ready_c;
      if (valid_w[k]) vcyc[k]++;
      if (valid_w[k] && !valid_prev[k]) vrise[k]++;
      if (busy_w[k] && !busy_prev[k]) nbusy[k]++;
      if (ov_w[k]) novr[k]++;
      if (bk_w[k]) nbrk[k]++;
      if (valid_w[k] && r) begin
        nacc[k]++;
        last_d[k] = int'(dw[k]); last_pe[k] = int'(pe_w[k]); last_fe[k] = int'(fe_w[k]);
        if (k == 2) begin
          if (exp_c.size() == 0) begin
            ntests++; nfail++;
            $display("FAIL c_extra_word: got %0h expected none", dw[k]);
          end else begin
            e = exp_c.pop_front();
            chk("c_data", dw[k], e.d);
            chk("c_perr", pe_w[k], e.pe);
            chk("c_ferr", fe_w[k], e.fe);
          end
        end
      end
    end
    valid_prev = valid_w;
    busy_prev  = busy_w;
  end

  task automatic snap(input int k);
    sacc[k] = nacc[k]; svcyc[k] = vcyc[k]; svrise[k] = vrise[k];
    sovr[k] = novr[k]; sbrk[k] = nbrk[k]; sbusy[k] = nbusy[k];
  endtask

  task automatic set_rx(input int w, input logic v);
    case (w)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Frame bits LSB-first, bit 0 = start; parity derived from the data, then optionally inverted.
  function automatic logic [15:0] mk_frame(input logic [8:0] d, input int ndb, input int pm, input int sb,
                                           input logic pflip, input logic [1:0] stopv);
    logic [15:0] f;
    logic par;
    int p;
    f = '1; f[0] = 1'b0; p = 1; par = 1'b0;
    for (int i = 0; i < ndb; i++) begin f[p] = d[i]; par ^= d[i]; p++; end
    if (pm != 0) begin f[p] = ((pm == 2) ? ~par : par) ^ pflip; p++; end
    for (int i = 0; i < sb; i++) begin f[p] = stopv[i]; p++; end
    return f;
  endfunction

  // A glitch_bit >= 0 pulls the line low for 20 clk around the middle of that bit.
  task automatic send_frame(input int w, input real bit_ns, input int n, input logic [15:0] bits,
                            input int glitch_bit);
    for (int i = 0; i < n; i++) begin
      set_rx(w, bits[i]);
      if (i == glitch_bit) begin
        #(bit_ns / 2 - 200.0); set_rx(w, 1'b0);
        #400;                  set_rx(w, bits[i]);
        #(bit_ns / 2 - 200.0);
      end else begin
        #(bit_ns);
      end
    end
    set_rx(w, 1'b1);
  endtask

  task automatic tests_a();
    snap(0);
    send_frame(0, BA, 10, mk_frame(9'h0A5, 8, 0, 1, 1'b0, 2'b11), 1);
    #(2 * BA);
    chk("a5_data", data_a, 8'hA5);
    chk("a5_accepted", nacc[0] - sacc[0], 1);
    chk("a5_valid_cycles", vcyc[0] - svcyc[0], 1);
    chk("a5_perr", last_pe[0], 0);
    chk("a5_ferr", last_fe[0], 0);
    chk("a5_overrun", novr[0] - sovr[0], 0);

    @(posedge clk); #2 ready_a = 1'b0;
    snap(0);
    send_frame(0, BA, 10, mk_frame(9'h011, 8, 0, 1, 1'b0, 2'b11), -1);
    #(BA);
    send_frame(0, BA, 10, mk_frame(9'h022, 8, 0, 1, 1'b0, 2'b11), -1);
    #(2 * BA);
    chk("ovr_valid_held", valid_a, 1);
    chk("ovr_data_kept", data_a, 8'h11);
    chk("ovr_pulses", novr[0] - sovr[0], 1);
    chk("ovr_valid_rises", vrise[0] - svrise[0], 1);
    @(posedge clk); #2 ready_a = 1'b1;
    @(posedge clk); #1;
    chk("ovr_valid_drop", valid_a, 0);
    chk("ovr_accepted_word", last_d[0], 8'h11);

    snap(0);
    set_rx(0, 1'b0); #(4.0 * BA / 16.0); set_rx(0, 1'b1);
    #(2 * BA);
    chk("glitch_busy_pulse", nbusy[0] - sbusy[0], 1);
    chk("glitch_busy_idle", busy_a, 0);
    chk("glitch_no_valid", vrise[0] - svrise[0], 0);
    chk("glitch_no_break", nbrk[0] - sbrk[0], 0);
    chk("glitch_no_overrun", novr[0] - sovr[0], 0);
    send_frame(0, BA, 10, mk_frame(9'h05A, 8, 0, 1, 1'b0, 2'b11), -1);
    #(2 * BA);
    chk("glitch_5a_data", last_d[0], 8'h5A);
    chk("glitch_5a_accepted", nacc[0] - sacc[0], 1);

    snap(0);
    set_rx(0, 1'b0); #(20 * BA); set_rx(0, 1'b1);
    #(2 * BA);
    chk("break_pulses", nbrk[0] - sbrk[0], 1);
    chk("break_no_valid", vrise[0] - svrise[0], 0);
    chk("break_busy_idle", busy_a, 0);
    @(posedge clk); #2 ready_a = 1'b0;
    send_frame(0, BA, 10, mk_frame(9'h0C3, 8, 0, 1, 1'b0, 2'b11), -1);
    #(2 * BA);
    chk("break_c3_valid", valid_a, 1);
    chk("break_c3_data", data_a, 8'hC3);
    chk("break_c3_flags", {pe_a, fe_a}, 0);

    fork
      send_frame(0, BA, 10, mk_frame(9'h0F0, 8, 0, 1, 1'b0, 2'b11), -1);
      begin
        #(5.5 * BA);
        chk("rstmid_busy_before", busy_a, 1);
        @(negedge clk); #2 rst_a = 1'b1;
        #3;
        chk("rstmid_data", data_a, 0);
        chk("rstmid_valid", valid_a, 0);
        chk("rstmid_busy", busy_a, 0);
        chk("rstmid_flags", {pe_a, fe_a, ov_a, bk_a}, 0);
        repeat (5) @(posedge clk);
        #2 rst_a = 1'b0;
      end
    join
    ready_a = 1'b1;
    #(2 * BA);
    snap(0);
    send_frame(0, BA, 10, mk_frame(9'h03C, 8, 0, 1, 1'b0, 2'b11), -1);
    #(2 * BA);
    chk("rst_3c_accepted", nacc[0] - sacc[0], 1);
    chk("rst_3c_data", last_d[0], 8'h3C);
    chk("rst_3c_flags", last_pe[0] + last_fe[0], 0);
  endtask

  task automatic tests_b();
    tbl[0] = '{9'h035, 1'b1, 2'b11, 0, 1, 0};
    tbl[1] = '{9'h035, 1'b0, 2'b11, 0, 0, 0};
    tbl[2] = '{9'h000, 1'b0, 2'b11, 0, 0, 0};
    tbl[3] = '{9'h07F, 1'b0, 2'b10, 0, 0, 1};
    tbl[4] = '{9'h02A, 1'b0, 2'b01, 0, 0, 1};
    tbl[5] = '{9'h000, 1'b0, 2'b00, 1, 0, 0};
    tbl[6] = '{9'h055, 1'b1, 2'b00, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      snap(1);
      send_frame(1, BB, 11, mk_frame(tbl[i].d, 7, 1, 2, tbl[i].pflip, tbl[i].stopv), -1);
      #(2 * BB);
      chk($sformatf("b%0d_break", i), nbrk[1] - sbrk[1], tbl[i].brk);
      chk($sformatf("b%0d_accepted", i), nacc[1] - sacc[1], 1 - tbl[i].brk);
      if (tbl[i].brk == 0) begin
        chk($sformatf("b%0d_data", i), last_d[1], tbl[i].d);
        chk($sformatf("b%0d_perr", i), last_pe[1], tbl[i].pe);
        chk($sformatf("b%0d_ferr", i), last_fe[1], tbl[i].fe);
      end
    end
  endtask

  task automatic rand_c();
    logic [8:0] d;
    logic pflip;
    logic [1:0] stopv;
    logic [15:0] f;
    int nbk = 0;
    for (int i = 0; i < 20; i++) begin
      d = 9'($urandom_range(0, 511));
      pflip = ($urandom_range(0, 3) == 0);
      stopv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      if ($urandom_range(0, 7) == 0) begin
        d = '0; pflip = 1'b1; stopv = 2'b00;
      end
      f = mk_frame(d, 9, 2, 2, pflip, stopv);
      if (d == 0 && f[10] == 1'b0 && stopv == 2'b00) nbk++;
      else exp_c.push_back('{int'(d), int'(pflip), int'(stopv != 2'b11)});
      send_frame(2, BC, 13, f, -1);
      #(2 * BC);
    end
    chk("c_all_words_seen", exp_c.size(), 0);
    chk("c_breaks", nbrk[2], nbk);
    chk("c_no_overrun", novr[2], 0);
  endtask

  initial begin
    ready_c = 1'b1;
    forever begin
      @(posedge clk); #2;
      ready_c = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_bc = 1'b1;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_valid", valid_w, 0);
    chk("reset_busy", busy_w, 0);
    chk("reset_data_a", data_a, 0);
    chk("reset_pulses", {ov_w, bk_w, pe_w, fe_w}, 0);
    rst_a = 1'b0; rst_bc = 1'b0;
    repeat (20) @(posedge clk);
    fork
      tests_a();
      tests_b();
      rand_c();
    join
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
